// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the MEM-stage bridge: address map, exception codes, FSM states.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam logic [4:0] ExcNone = 5'd0;
  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;

  // One-hot target vector bit positions
  localparam int unsigned NumTgt = 4;
  localparam int unsigned TgtDm  = 0;
  localparam int unsigned TgtTc0 = 1;
  localparam int unsigned TgtTc1 = 2;
  localparam int unsigned TgtIg  = 3;

  localparam logic [31:0] Tc0Base = 32'h0000_7F00;
  localparam logic [31:0] Tc0Last = 32'h0000_7F0B;
  localparam logic [31:0] Tc1Base = 32'h0000_7F10;
  localparam logic [31:0] Tc1Last = 32'h0000_7F1B;
  localparam logic [31:0] IgBase  = 32'h0000_7F20;
  localparam logic [31:0] IgLast  = 32'h0000_7F23;

  // Word offset of the read-only timer count register
  localparam logic [1:0] TcCountWord = 2'd2;

  function automatic logic in_range(logic [31:0] a, logic [31:0] lo, logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address decoder: picks the target device and flags illegal accesses.
module mem_addr_decode
  import mem_bridge_pkg::*;
#(
  parameter int unsigned DM_WORDS = 3072
) (
  input  logic [31:0]       addr_i,
  input  logic              read_i,
  input  logic [3:0]        byte_en_i,
  output logic [NumTgt-1:0] tgt_o,
  output logic              err_o
);

  logic [31:0]       dm_limit;
  logic [NumTgt-1:0] tgt;

  assign dm_limit = 32'(DM_WORDS * 4);

  always_comb begin
    tgt   = '0;
    err_o = 1'b0;
    if (addr_i < dm_limit) begin
      tgt[TgtDm] = 1'b1;
    end else if (in_range(addr_i, Tc0Base, Tc0Last)) begin
      tgt[TgtTc0] = 1'b1;
    end else if (in_range(addr_i, Tc1Base, Tc1Last)) begin
      tgt[TgtTc1] = 1'b1;
    end else if (in_range(addr_i, IgBase, IgLast)) begin
      tgt[TgtIg] = 1'b1;
    end

    if (tgt == '0) begin
      err_o = 1'b1;
    end else if (!read_i && !tgt[TgtDm]) begin
      // Peripheral registers only accept full-word stores; timer count is read-only
      if (byte_en_i != 4'b1111) err_o = 1'b1;
      if (!tgt[TgtIg] && addr_i[3:2] == TcCountWord) err_o = 1'b1;
    end
  end

  assign tgt_o = tgt;

endmodule

// File: rtl/mem_bridge.sv
// MEM-stage bridge: latches one access, strobes the decoded device until ack or timeout,
// then reports completion with a one-cycle rsp_valid pulse.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned DM_WORDS    = 3072,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteEn,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_exc,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_byteEn,
  output logic        dm_strobe,
  output logic        tc0_strobe,
  output logic        tc1_strobe,
  output logic        ig_strobe,
  input  logic        dev_ack,
  input  logic [31:0] dev_rdata
);

  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [NumTgt-1:0] tgt_q, tgt_d;
  logic              read_q, read_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [4:0]        exc_q, exc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [NumTgt-1:0] dec_tgt;
  logic              dec_err;

  mem_addr_decode #(
    .DM_WORDS(DM_WORDS)
  ) u_decode (
    .addr_i   (req_addr),
    .read_i   (req_read),
    .byte_en_i(req_byteEn),
    .tgt_o    (dec_tgt),
    .err_o    (dec_err)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    read_d  = read_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          tgt_d   = dec_tgt;
          read_d  = req_read;
          addr_d  = {req_addr[31:2], 2'b00};
          wdata_d = req_wdata;
          be_d    = req_read ? 4'b0000 : req_byteEn;
          cnt_d   = '0;
          if (dec_err) begin
            state_d = StDone;
            exc_d   = req_read ? ExcAdEL : ExcAdES;
            rdata_d = '0;
          end else if (!req_read && req_byteEn == 4'b0000) begin
            state_d = StDone;
            exc_d   = ExcNone;
            rdata_d = '0;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (dev_ack) begin
          state_d = StDone;
          exc_d   = ExcNone;
          rdata_d = read_q ? dev_rdata : '0;
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          exc_d   = read_q ? ExcAdEL : ExcAdES;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      tgt_q   <= '0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      exc_q   <= ExcNone;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall      = (state_q == StIdle && req_valid) || (state_q == StAccess);
  assign rsp_valid  = (state_q == StDone);
  assign rsp_rdata  = rdata_q;
  assign rsp_exc    = exc_q;
  assign dev_addr   = addr_q;
  assign dev_wdata  = wdata_q;
  assign dev_byteEn = be_q;
  assign dm_strobe  = (state_q == StAccess) && tgt_q[TgtDm];
  assign tc0_strobe = (state_q == StAccess) && tgt_q[TgtTc0];
  assign tc1_strobe = (state_q == StAccess) && tgt_q[TgtTc1];
  assign ig_strobe  = (state_q == StAccess) && tgt_q[TgtIg];

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: hand-computed latency, strobe, exception and data checks.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_read;
  logic [31:0] req_addr;
  logic [3:0]  req_byteEn;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_exc;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_byteEn;
  logic        dm_strobe;
  logic        tc0_strobe;
  logic        tc1_strobe;
  logic        ig_strobe;
  logic        dev_ack;
  logic [31:0] dev_rdata;

  logic [3:0] strobes;
  assign strobes = {ig_strobe, tc1_strobe, tc0_strobe, dm_strobe};

  mem_bridge #(
    .DM_WORDS   (3072),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_read  (req_read),
    .req_addr  (req_addr),
    .req_byteEn(req_byteEn),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_exc   (rsp_exc),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_byteEn(dev_byteEn),
    .dm_strobe (dm_strobe),
    .tc0_strobe(tc0_strobe),
    .tc1_strobe(tc1_strobe),
    .ig_strobe (ig_strobe),
    .dev_ack   (dev_ack),
    .dev_rdata (dev_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Results captured by run_req
  int          r_lat;
  int          r_stb_cycles;
  int          r_bad;
  logic [3:0]  r_stb_or;
  logic [4:0]  r_exc;
  logic [31:0] r_rdata;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [3:0]  r_be;
  logic        r_stall0;
  logic        r_done;
  logic        r_idle_valid;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ack_at: 1-based strobe cycle in which dev_ack is raised; 0 = never
  task automatic run_req(input logic rd, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] ack_data);
    req_valid    = 1'b1;
    req_read     = rd;
    req_addr     = addr;
    req_byteEn   = be;
    req_wdata    = wd;
    dev_ack      = 1'b0;
    dev_rdata    = ack_data;
    #1;
    r_stall0     = stall;
    r_lat        = 0;
    r_stb_cycles = 0;
    r_bad        = 0;
    r_stb_or     = '0;
    r_exc        = '0;
    r_rdata      = '0;
    r_done       = 1'b0;
    for (int c = 1; c <= 40 && !r_done; c++) begin
      step();
      if (rsp_valid) begin
        r_done    = 1'b1;
        r_lat     = c;
        r_exc     = rsp_exc;
        r_rdata   = rsp_rdata;
        if (stall !== 1'b0 || strobes !== 4'b0000) r_bad++;
        req_valid = 1'b0;
        dev_ack   = 1'b0;
      end else begin
        if (strobes != 4'b0000) begin
          r_stb_cycles++;
          r_stb_or |= strobes;
          if ($countones(strobes) != 1 || stall !== 1'b1) r_bad++;
          r_addr = dev_addr;
          r_wd   = dev_wdata;
          r_be   = dev_byteEn;
        end
        dev_ack = (ack_at != 0) && (r_stb_cycles == ack_at);
      end
    end
    check_eq("rsp_within_budget", 32'(r_done), 32'd1);
    step();
    r_idle_valid = rsp_valid;
  endtask

  task automatic expect_req(input string tag, input int lat, input logic [4:0] exc,
                            input logic [31:0] rdata, input logic [3:0] stb, input int cyc);
    check_eq({tag, ".stall_accept"}, 32'(r_stall0), 32'd1);
    check_eq({tag, ".latency"}, 32'(r_lat), 32'(lat));
    check_eq({tag, ".exc"}, 32'(r_exc), 32'(exc));
    check_eq({tag, ".rdata"}, r_rdata, rdata);
    check_eq({tag, ".strobe_vec"}, 32'(r_stb_or), 32'(stb));
    check_eq({tag, ".strobe_cycles"}, 32'(r_stb_cycles), 32'(cyc));
    check_eq({tag, ".onehot_stall"}, 32'(r_bad), 32'd0);
    check_eq({tag, ".single_pulse"}, 32'(r_idle_valid), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_read   = 1'b0;
    req_addr   = '0;
    req_byteEn = '0;
    req_wdata  = '0;
    dev_ack    = 1'b0;
    dev_rdata  = '0;
    step();
    step();
    reset = 1'b0;
    step();
    check_eq("rst.stall", 32'(stall), 32'd0);
    check_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst.rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst.rsp_exc", 32'(rsp_exc), 32'd0);
    check_eq("rst.dev_addr", dev_addr, 32'd0);
    check_eq("rst.dev_wdata", dev_wdata, 32'd0);
    check_eq("rst.dev_byteEn", 32'(dev_byteEn), 32'd0);
    check_eq("rst.strobes", 32'(strobes), 32'd0);

    // DM load, immediate ack
    run_req(1'b1, 32'h0000_0010, 4'b0000, 32'h0, 1, 32'h1234_5678);
    expect_req("dm_load", 2, 5'd0, 32'h1234_5678, 4'b0001, 1);
    check_eq("dm_load.dev_addr", r_addr, 32'h0000_0010);
    check_eq("dm_load.dev_byteEn", 32'(r_be), 32'd0);

    // DM byte store, lane 2
    run_req(1'b0, 32'h0000_0022, 4'b0100, 32'h00AB_0000, 1, 32'hFFFF_FFFF);
    expect_req("dm_store", 2, 5'd0, 32'h0, 4'b0001, 1);
    check_eq("dm_store.dev_addr", r_addr, 32'h0000_0020);
    check_eq("dm_store.dev_byteEn", 32'(r_be), 32'h4);
    check_eq("dm_store.dev_wdata", r_wd, 32'h00AB_0000);

    // Partial store to TC0 is an address error
    run_req(1'b0, 32'h0000_7F04, 4'b0011, 32'h0, 1, 32'h0);
    expect_req("tc0_partial", 1, 5'd5, 32'h0, 4'b0000, 0);

    // Unmapped load
    run_req(1'b1, 32'h0000_7F30, 4'b0000, 32'h0, 1, 32'h0);
    expect_req("unmapped_ld", 1, 5'd4, 32'h0, 4'b0000, 0);

    // TC1 load, ack after 3 wait cycles
    run_req(1'b1, 32'h0000_7F18, 4'b0000, 32'h0, 4, 32'hCAFE_0001);
    expect_req("tc1_wait", 5, 5'd0, 32'hCAFE_0001, 4'b0100, 4);

    // IG load, never acked
    run_req(1'b1, 32'h0000_7F20, 4'b0000, 32'h0, 0, 32'h0);
    expect_req("ig_timeout", 16, 5'd4, 32'h0, 4'b1000, 15);

    // Store to read-only count register
    run_req(1'b0, 32'h0000_7F08, 4'b1111, 32'h1, 1, 32'h0);
    expect_req("tc0_count_st", 1, 5'd5, 32'h0, 4'b0000, 0);

    // Last DM word, then first address past DM
    run_req(1'b1, 32'h0000_2FFC, 4'b0000, 32'h0, 1, 32'h0BAD_F00D);
    expect_req("dm_last", 2, 5'd0, 32'h0BAD_F00D, 4'b0001, 1);
    run_req(1'b1, 32'h0000_3000, 4'b0000, 32'h0, 1, 32'h0);
    expect_req("dm_past_end", 1, 5'd4, 32'h0, 4'b0000, 0);

    // Zero byte-enable store is a no-op; also clears previously loaded data
    run_req(1'b1, 32'h0000_0004, 4'b0000, 32'h0, 1, 32'h7777_7777);
    run_req(1'b0, 32'h0000_0040, 4'b0000, 32'h5, 1, 32'h0);
    expect_req("dm_noop", 1, 5'd0, 32'h0, 4'b0000, 0);

    // TC0 full-word store, one wait cycle
    run_req(1'b0, 32'h0000_7F04, 4'b1111, 32'h0000_0055, 2, 32'h0);
    expect_req("tc0_store", 3, 5'd0, 32'h0, 4'b0010, 2);
    check_eq("tc0_store.dev_wdata", r_wd, 32'h0000_0055);

    // Reset during ACCESS cycle 2 of an IG load
    req_valid  = 1'b1;
    req_read   = 1'b1;
    req_addr   = 32'h0000_7F20;
    req_byteEn = 4'b0000;
    dev_ack    = 1'b0;
    step();
    check_eq("rst_mid.ig_strobe_c1", 32'(strobes), 32'h8);
    step();
    check_eq("rst_mid.ig_strobe_c2", 32'(strobes), 32'h8);
    reset     = 1'b1;
    req_valid = 1'b0;
    step();
    check_eq("rst_mid.strobes", 32'(strobes), 32'd0);
    check_eq("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_mid.stall", 32'(stall), 32'd0);
    check_eq("rst_mid.dev_addr", dev_addr, 32'd0);
    reset = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (rsp_valid || strobes != 4'b0000) seen++;
      end
      check_eq("rst_mid.no_rsp", 32'(seen), 32'd0);
    end
    // Back in IDLE: a fresh request has normal latency
    run_req(1'b1, 32'h0000_0100, 4'b0000, 32'h0, 1, 32'hA5A5_5A5A);
    expect_req("after_rst", 2, 5'd0, 32'hA5A5_5A5A, 4'b0001, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter DM_WORDS, 3072, number of 32-bit data-memory words (12 KB) decoded from 0x0000_0000.
REQ-002 Parameter ACK_TIMEOUT, 15, maximum cycles to wait for a device ack after its strobe.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock; all state on rising edge.
- reset, in, 1, synchronous active-high reset.
- req_valid, in, 1, MEM-stage access request; held with stable fields until rsp_valid.
- req_read, in, 1, 1 = load, 0 = store.
- req_addr, in, 32, byte address.
- req_byteEn, in, 4, store byte enables, aligned to the word lane.
- req_wdata, in, 32, store data, already lane-shifted.
- stall, out, 1, freeze pipeline at MEM.
- rsp_valid, out, 1, one-cycle completion pulse.
- rsp_rdata, out, 32, raw loaded word, valid with rsp_valid.
- rsp_exc, out, 5, 0 = none, 4 = AdEL, 5 = AdES; valid with rsp_valid.
- dev_addr, out, 32, registered word address (bits 1:0 = 0).
- dev_wdata, out, 32, registered store data.
- dev_byteEn, out, 4, registered byte enables; 0000 on reads.
- dm_strobe, out, 1, data-memory access strobe.
- tc0_strobe, out, 1, Timer0 access strobe.
- tc1_strobe, out, 1, Timer1 access strobe.
- ig_strobe, out, 1, interrupt-generator access strobe.
- dev_ack, in, 1, ack from the strobed device; qualifies dev_rdata.
- dev_rdata, in, 32, read data from the strobed device.

Function
REQ-004 FSM states: IDLE, ACCESS, DONE.
REQ-005 IDLE: when req_valid=1, latch req fields, decode the target, and go to ACCESS; stall=1 combinationally in that same cycle.
REQ-006 Decode map:
- DM: 0x0000_0000 .. 4*DM_WORDS-1.
- TC0: 0x7F00–0x7F0B.
- TC1: 0x7F10–0x7F1B.
- IG: 0x7F20–0x7F23.
- All other addresses are unmapped.
REQ-007 Decode errors, checked at latch; on error no strobe is issued and the block goes straight to DONE with rsp_exc=4 (load) or 5 (store):
- unmapped address;
- store to TC0, TC1 or IG with byteEn ≠ 1111;
- store to TC0/TC1 offset 8 (count register, read-only).
REQ-008 Store with byteEn=0000 is a no-op: no strobe, go to DONE, rsp_exc=0.
REQ-009 ACCESS: exactly one strobe high each cycle, with dev_* stable, until dev_ack=1; capture dev_rdata on the ack cycle; then go to DONE.
REQ-010 Timeout: if dev_ack does not arrive within ACK_TIMEOUT cycles of entering ACCESS, drop the strobe, go to DONE, rsp_exc=4/5.
REQ-011 DONE: lasts one cycle with rsp_valid=1 and stall=0; req_valid is ignored in DONE; next state is IDLE.
REQ-012 Latency: with ack in the first ACCESS cycle, a request accepted in cycle N yields rsp_valid in N+2; each wait cycle adds one.
REQ-013 rsp_rdata holds the last captured value; it is 0 after an error, a no-op or a store.
REQ-014 stall = (IDLE & req_valid) | ACCESS.

Reset
REQ-015 Reset value of every output: state=IDLE, all strobes 0, stall 0 (absent req_valid), rsp_valid 0, rsp_rdata 0, rsp_exc 0, dev_addr 0, dev_wdata 0, dev_byteEn 0, timeout counter 0.
REQ-016 Reset asserted mid-ACCESS drops the strobe in the following cycle and emits no rsp_valid for the aborted request.

Structure
REQ-017 The shared macros file holds the address-map bounds, exception codes (EXC_none=0, EXC_AdEL=4, EXC_AdES=5) and FSM state encodings.
REQ-018 One sub-module, mem_addr_decode, is combinational: addr, read, byteEn in; target one-hot and error flag out.

Verification
REQ-019 DM load at 0x0000_0010 with ack in the first ACCESS cycle and dev_rdata=0x1234_5678 -> dm_strobe for 1 cycle, rsp_valid at N+2, rsp_rdata=0x1234_5678, rsp_exc=0.
REQ-020 Store byteEn=0100 to 0x0000_0022, wdata=0x00AB_0000 -> dev_addr=0x0000_0020, dev_byteEn=0100, dm_strobe=1, rsp_exc=0.
REQ-021 Store byteEn=0011 to 0x7F04 -> no strobe, rsp_valid at N+1, rsp_exc=5; load from 0x7F30 -> rsp_exc=4.
REQ-022 TC1 load at 0x7F18 with ack delayed 3 cycles -> tc1_strobe high for 4 cycles, stall high throughout, rsp_valid in cycle N+5.
REQ-023 IG load with no ack -> strobe drops after 15 cycles, rsp_exc=4; reset pulsed in ACCESS cycle 2 of another request -> strobe 0 next cycle, no rsp_valid, FSM in IDLE.
